uart_byte_tx: RTL and testbench

//  Serialises one byte per request onto the UART line (LSB first, optional parity, 1/2 stop bits).

---
 rtl/uart_byte_tx_if.sv | 22 ++
 rtl/uart_byte_tx.sv | 154 +++++++++++++++
 tb/tb_uart_byte_tx.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_byte_tx_if.sv
// Byte request/handshake bundle between the frame builder
// and the UART byte transmitter.
interface uart_byte_tx_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_state;
  logic       tx_done;

  modport master (
    output tx_start,
    output tx_data,
    input  tx_state,
    input  tx_done
  );

  modport slave (
    input  tx_start,
    input  tx_data,
    output tx_state,
    output tx_done
  );
endinterface

// File: rtl/uart_byte_tx.sv
// UART byte transmitter: start, 8 data bits LSB first,
// optional parity, 1 or 2 stop bits; gapless streaming.
module uart_byte_tx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic          clk_in,
  input  logic          rst_in,
  uart_byte_tx_if.slave tx_if,
  output logic          rs232_tx
);
  localparam int BIT_CNT = CLK_FREQ / BAUD_RATE;
  localparam logic [15:0] BIT_LAST = 16'(BIT_CNT - 1);

  if (BIT_CNT < 2 || BIT_CNT > 65535) begin : g_bad_baud
    $error("uart_byte_tx: BIT_CNT out of range");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $error("uart_byte_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_byte_tx: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t      r_state, w_state;
  logic [15:0] r_baud, w_baud;
  logic [2:0]  r_idx, w_idx;
  logic        r_stop, w_stop;
  logic [7:0]  r_data, w_data;
  logic        r_par, w_par;
  logic        r_tx, w_tx;
  logic        r_busy, w_busy;
  logic        r_done, w_done;

  logic w_wrap;
  logic w_stop_last;
  logic w_par_in;

  assign w_wrap      = (r_baud == BIT_LAST);
  assign w_stop_last = (STOP_BITS == 1) || r_stop;
  assign w_par_in    = (PARITY == 2) ? ^tx_if.tx_data
                                     : ~^tx_if.tx_data;

  always_comb begin
    w_state = r_state;
    w_baud  = r_baud;
    w_idx   = r_idx;
    w_stop  = r_stop;
    w_data  = r_data;
    w_par   = r_par;
    w_tx    = r_tx;
    w_busy  = r_busy;
    w_done  = 1'b0;
    if (r_busy) begin
      w_baud = w_wrap ? 16'd0 : r_baud + 16'd1;
    end
    unique case (r_state)
      S_START: begin
        if (w_wrap) begin
          w_state = S_DATA;
          w_idx   = 3'd0;
          w_tx    = r_data[0];
        end
      end
      S_DATA: begin
        if (w_wrap) begin
          if (r_idx == 3'd7) begin
            if (PARITY != 0) begin
              w_state = S_PAR;
              w_tx    = r_par;
            end else begin
              w_state = S_STOP;
              w_stop  = 1'b0;
              w_tx    = 1'b1;
            end
          end else begin
            w_idx  = r_idx + 3'd1;
            w_data = {1'b0, r_data[7:1]};
            w_tx   = r_data[1];
          end
        end
      end
      S_PAR: begin
        if (w_wrap) begin
          w_state = S_STOP;
          w_stop  = 1'b0;
          w_tx    = 1'b1;
        end
      end
      S_STOP: begin
        if (w_wrap) begin
          if (w_stop_last) begin
            w_state = S_IDLE;
            w_busy  = 1'b0;
            w_done  = 1'b1;
            w_tx    = 1'b1;
          end else begin
            w_stop = 1'b1;
          end
        end
      end
      default: ;
    endcase
    // Accepting on the completion edge keeps streams gapless.
    if (!w_busy && tx_if.tx_start) begin
      w_state = S_START;
      w_busy  = 1'b1;
      w_baud  = 16'd0;
      w_idx   = 3'd0;
      w_stop  = 1'b0;
      w_tx    = 1'b0;
      w_data  = tx_if.tx_data;
      w_par   = w_par_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
      r_baud  <= 16'd0;
      r_idx   <= 3'd0;
      r_stop  <= 1'b0;
      r_data  <= 8'd0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_baud  <= w_baud;
      r_idx   <= w_idx;
      r_stop  <= w_stop;
      r_data  <= w_data;
      r_par   <= w_par;
      r_tx    <= w_tx;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end

  assign rs232_tx       = r_tx;
  assign tx_if.tx_state = r_busy;
  assign tx_if.tx_done  = r_done;
endmodule

// File: tb/tb_uart_byte_tx.sv
// Bench: four transmitter configs driven in parallel,
// checked every cycle against a frame-bit-array model.
module tb_uart_byte_tx;
  localparam int BC = 16;
  localparam int NI = 4;
  localparam int LN = 400;
  localparam int PAR_T [NI] = '{0, 0, 2, 1};
  localparam int STP_T [NI] = '{1, 2, 1, 1};

  logic       clk;
  logic       rst;
  logic       tx_start;
  logic [7:0] tx_data;

  logic line_w  [NI];
  logic state_w [NI];
  logic done_w  [NI];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : gi
    uart_byte_tx_if ifc ();
    logic line;
    assign ifc.tx_start = tx_start;
    assign ifc.tx_data  = tx_data;
    uart_byte_tx #(
      .CLK_FREQ (160),
      .BAUD_RATE(10),
      .PARITY   (PAR_T[g]),
      .STOP_BITS(STP_T[g])
    ) dut (
      .clk_in  (clk),
      .rst_in  (rst),
      .tx_if   (ifc),
      .rs232_tx(line)
    );
    assign line_w[g]  = line;
    assign state_w[g] = ifc.tx_state;
    assign done_w[g]  = ifc.tx_done;
  end

  int n_chk;
  int n_err;
  int cyc;

  logic        mb [NI];
  logic        ml [NI];
  logic        md [NI];
  int          mt [NI];
  logic [11:0] mf [NI];

  logic ln [NI][LN];
  int   dn1 [NI];
  int   dn2 [NI];

  function automatic int nbits(input int i);
    return 9 + ((PAR_T[i] != 0) ? 1 : 0) + STP_T[i];
  endfunction

  function automatic logic [11:0] frame(input int i,
                                        input logic [7:0] d);
    logic [11:0] b;
    b = '1;
    b[0] = 1'b0;
    b[8:1] = d;
    if (PAR_T[i] == 2) b[9] = ^d;
    if (PAR_T[i] == 1) b[9] = ~^d;
    return b;
  endfunction

  function automatic logic [11:0] fbits(input int i,
                                        input int off);
    logic [11:0] b;
    b = '0;
    for (int k = 0; k < 12; k++) begin
      if (off + 8 + BC * k < LN) b[k] = ln[i][off + 8 + BC * k];
    end
    return b;
  endfunction

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  // Advance one clock: the model consumes the inputs that
  // were present at the rising edge, then outputs compare.
  task automatic tick();
    @(negedge clk);
    cyc++;
    for (int i = 0; i < NI; i++) begin
      md[i] = 1'b0;
      if (rst) begin
        mb[i] = 1'b0;
        ml[i] = 1'b1;
        mt[i] = 0;
      end else begin
        if (mb[i]) begin
          mt[i]++;
          if (mt[i] == nbits(i) * BC) begin
            mb[i] = 1'b0;
            md[i] = 1'b1;
            ml[i] = 1'b1;
          end else begin
            ml[i] = mf[i][mt[i] / BC];
          end
        end
        if (!mb[i] && tx_start) begin
          mf[i] = frame(i, tx_data);
          mb[i] = 1'b1;
          mt[i] = 0;
          ml[i] = 1'b0;
        end
      end
      n_chk++;
      if ({line_w[i], state_w[i], done_w[i]} !==
          {ml[i], mb[i], md[i]}) begin
        n_err++;
        $display("FAIL cyc%0d inst%0d line/state/done got %b%b%b want %b%b%b",
                 cyc, i, line_w[i], state_w[i], done_w[i],
                 ml[i], mb[i], md[i]);
      end
    end
  endtask

  // Called right after a tick; j counts cycles after accept.
  task automatic run(input logic [7:0] d, input logic [7:0] d2,
                     input int hold, input int pj, input int rj,
                     input int len);
    tx_start = 1'b1;
    tx_data  = d;
    for (int i = 0; i < NI; i++) begin
      dn1[i] = -1;
      dn2[i] = -1;
    end
    for (int j = 0; j < len; j++) begin
      tick();
      for (int i = 0; i < NI; i++) begin
        ln[i][j] = line_w[i];
        if (done_w[i]) begin
          if (dn1[i] < 0) dn1[i] = j;
          else if (dn2[i] < 0) dn2[i] = j;
        end
      end
      tx_start = (j + 1 < hold) || (j == pj);
      tx_data  = (j == pj) ? 8'hFF : d2;
      rst      = (j == rj);
    end
    tx_start = 1'b0;
    rst      = 1'b0;
    repeat (3) tick();
  endtask

  logic [11:0] fb;

  initial begin
    n_chk = 0;
    n_err = 0;
    cyc   = 0;
    for (int i = 0; i < NI; i++) begin
      mb[i] = 1'b0;
      ml[i] = 1'b1;
      md[i] = 1'b0;
      mt[i] = 0;
      mf[i] = '1;
    end
    rst      = 1'b1;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    tick();
    for (int k = 0; k < 3; k++) begin
      tx_start = ~tx_start;
      tx_data  = 8'h5A;
      tick();
      chk("rst_line", int'(line_w[0]), 1);
      chk("rst_state", int'(state_w[0]), 0);
      chk("rst_done", int'(done_w[0]), 0);
    end
    rst      = 1'b0;
    tx_start = 1'b0;
    repeat (2) tick();

    run(8'hA5, 8'h00, 1, -1, -1, 200);
    fb = fbits(0, 0);
    chk("8n1_a5_bits", int'(fb[9:0]), 'h34A);
    chk("8n1_done_at", dn1[0], 160);
    chk("8n1_one_done", dn2[0], -1);
    fb = fbits(1, 0);
    chk("8n2_stops", int'(fb[10:9]), 3);
    chk("8n2_done_at", dn1[1], 176);
    fb = fbits(2, 0);
    chk("8e1_a5_par", int'(fb[9]), 0);
    chk("8e1_done_at", dn1[2], 176);
    fb = fbits(3, 0);
    chk("8o1_a5_par", int'(fb[9]), 1);

    run(8'h07, 8'hFF, 1, -1, -1, 200);
    fb = fbits(0, 0);
    chk("8n1_07_bits", int'(fb[9:0]), 'h20E);
    fb = fbits(2, 0);
    chk("8e1_07_par", int'(fb[9]), 1);
    chk("8e1_07_stop", int'(fb[10]), 1);
    fb = fbits(3, 0);
    chk("8o1_07_par", int'(fb[9]), 0);

    run(8'h00, 8'h00, 1, -1, -1, 200);
    fb = fbits(3, 0);
    chk("8o1_00_par", int'(fb[9]), 1);
    fb = fbits(2, 0);
    chk("8e1_00_par", int'(fb[9]), 0);

    run(8'h00, 8'h00, 1, 40, 80, 100);
    chk("busy_ign_bit", int'(ln[0][56]), 0);
    chk("mid_rst_line", int'(ln[0][81]), 1);
    for (int i = 0; i < NI; i++) begin
      chk("mid_rst_nodone", dn1[i], -1);
    end

    run(8'h3C, 8'h00, 1, -1, -1, 200);
    fb = fbits(0, 0);
    chk("post_rst_bits", int'(fb[9:0]), 'h278);
    chk("post_rst_done", dn1[0], 160);

    run(8'h55, 8'h3C, 177, -1, -1, LN);
    fb = fbits(1, 0);
    chk("b2b_f1_bits", int'(fb[10:0]), 'h6AA);
    fb = fbits(1, 176);
    chk("b2b_f2_bits", int'(fb[10:0]), 'h678);
    chk("b2b_done1", dn1[1], 176);
    chk("b2b_done2", dn2[1], 352);
    chk("b2b_last_d7", int'(ln[1][143]), 0);
    chk("b2b_stop_lo", int'(ln[1][144]), 1);
    chk("b2b_stop_hi", int'(ln[1][175]), 1);
    chk("b2b_start2", int'(ln[1][176]), 0);
    chk("b2b_8n1_d2", dn2[0], 320);

    for (int n = 0; n < 5000; n++) begin
      tick();
      tx_data = 8'($urandom);
      if ((n / 600) % 2 == 1)
        tx_start = ($urandom_range(0, 7) != 0);
      else
        tx_start = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 999) == 0);
    end
    rst      = 1'b0;
    tx_start = 1'b0;
    repeat (200) tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
